// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of one register-file read port: select, settle, capture with XZR
// and write bypass, then hand the result back over a valid/ready response.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [ADDR_W-1:0]            rf_sel,
    input  logic [DATA_W-1:0]            rf_rdata,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    input  logic                         rsp_ready,
    output logic                         busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(31);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_id;
    logic [ADDR_W-1:0]   win_addr;

    // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        int   ptr;
        logic found;
        grant    = '0;
        win_id   = '0;
        win_addr = '0;
        found    = 1'b0;
        ptr      = (int'(rr_ptr_q) >= int'(NUM_REQ)) ? 0 : int'(rr_ptr_q);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req_valid[i] && i >= ptr) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_id   = i[ID_W-1:0];
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req_valid[i] && i < ptr) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_id   = i[ID_W-1:0];
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    rsp_id_d = win_id;
                    addr_d   = win_addr;
                    cnt_d    = CNT_W'(SETTLE_CYC - 1);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    // XZR beats bypass; bypass beats the (possibly stale) mux output.
                    if (addr_q == XZR) begin
                        rsp_data_d = '0;
                    end else if (wr_en && wr_addr == addr_q) begin
                        rsp_data_d = wr_data;
                    end else begin
                        rsp_data_d = rf_rdata;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == StIdle && !reset) ? grant : '0;
    assign rf_sel    = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomised bench: transaction-level model predicts grants, select and captured data;
// a scoreboard queue feeds a separate response monitor.
module tb_regfile_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int S  = 2;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [AW-1:0]     rf_sel;
    logic [DW-1:0]     rf_rdata;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ready;
    logic              busy;

    regfile_read_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SETTLE_CYC (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rf_sel    (rf_sel),
        .rf_rdata  (rf_rdata),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mux output depends on the select and on time, so a wrong select or sample edge shows.
    function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a, input int c);
        return {32'(c), 27'h2ABCDEF, a};
    endfunction
    assign rf_rdata = rdata_fn(rf_sel, cyc);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model: one transaction at a time, timestamped by accept cycle.
    int            m_ptr  = 0;
    bit            m_busy = 0;
    int            m_id, m_acc, m_cap;
    logic [AW-1:0] m_addr;

    always @(negedge clk) begin
        logic [NR-1:0] er;
        logic [DW-1:0] ed;
        if (reset) begin
            m_busy = 0;
            m_ptr  = 0;
            sb.delete();
        end else begin
            er = '0;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (req_valid[idx] && er == '0) er[idx] = 1'b1;
                end
            end
            chk("req_ready", DW'(req_ready), DW'(er));
            chk("busy", DW'(busy), DW'(m_busy));
            chk("rsp_valid", DW'(rsp_valid), DW'(m_busy && cyc > m_cap));
            if (m_busy) begin
                if (cyc > m_acc) chk("rf_sel", DW'(rf_sel), DW'(m_addr));
                if (cyc == m_cap) begin
                    if (m_addr == 5'd31)                      ed = '0;
                    else if (wr_en && wr_addr == m_addr)      ed = wr_data;
                    else                                      ed = rdata_fn(m_addr, cyc);
                    sb.push_back('{m_id, ed});
                end
                if (cyc > m_cap && rsp_ready) begin
                    m_busy = 0;
                    m_ptr  = (m_id + 1) % NR;
                end
            end else if (er != '0) begin
                for (int k = 0; k < NR; k++) if (er[k]) m_id = k;
                m_addr = req_addr[m_id*AW +: AW];
                m_busy = 1;
                m_acc  = cyc;
                m_cap  = cyc + S;
            end
        end
    end

    // Response monitor: compare against the scoreboard head while valid, pop on handshake.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected @cyc %0d: got id %0d data %h expected none",
                         cyc, rsp_id, rsp_data);
            end else begin
                chk("rsp_id", DW'(rsp_id), DW'(sb[0].id));
                chk("rsp_data", rsp_data, sb[0].data);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    logic [NR-1:0] granted = '0;
    always @(negedge clk) granted <= req_valid & req_ready;

    bit            pend [NR];
    logic [AW-1:0] paddr[NR];

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
    endfunction

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]           = pend[i];
            req_addr[i*AW +: AW]   = paddr[i];
        end
    endtask

    // mode 0: random, 1: all requesting with rsp_ready=1, 2: stall, 3: no requests
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (granted[i]) pend[i] = 0;
            if (mode == 3) begin
                pend[i] = 0;
            end else if (!pend[i]) begin
                if (mode == 1 || $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1;
                    paddr[i] = rand_addr();
                end
            end else if (mode == 0 && $urandom_range(0, 31) == 0) begin
                pend[i] = 0;
            end
        end
        rsp_ready = (mode == 2) ? 1'b0 : (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        wr_en     = 1'($urandom_range(0, 1));
        wr_addr   = $urandom_range(0, 1) ? paddr[$urandom_range(0, NR - 1)]
                                         : 5'($urandom_range(0, 31));
        wr_data   = {$urandom, $urandom};
        apply();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, DW'(req_ready), '0);
        chk({tag, "_rf_sel"},    DW'(rf_sel),    '0);
        chk({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
        chk({tag, "_rsp_id"},    DW'(rsp_id),    '0);
        chk({tag, "_rsp_data"},  rsp_data,       '0);
        chk({tag, "_busy"},      DW'(busy),      '0);
    endtask

    initial begin
        bit hit;
        reset     = 1'b1;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int i = 0; i < NR; i++) begin
            pend[i]  = 1;
            paddr[i] = 5'(i + 3);
        end
        apply();
        #3;
        chk_reset_outputs("por");
        for (int i = 0; i < NR; i++) pend[i] = 0;
        apply();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (25)  step(1);
        repeat (12)  step(2);
        repeat (10)  step(1);
        repeat (600) step(0);
        repeat (20)  step(1);

        hit = 0;
        for (int n = 0; n < 50 && !hit; n++) begin
            step(1);
            if (busy && !rsp_valid) hit = 1;
        end
        chk("settle_reached", DW'(hit), DW'(1));
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("mid");
        for (int i = 0; i < NR; i++) pend[i] = 0;
        apply();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
